seq_restoring_divider: RTL

- Iterative radix-2 restoring divider. It is the inverse operation of the team's 16x16 multiplier.
- Takes a 32-bit dividend (the multiplier's product width) and a 16-bit divisor. Returns a 32-bit quotient and a 16-bit remainder.
- Produces one quotient bit per clock.
- Sits downstream of the multiplier datapath for scaling and normalisation. Uses valid/ready handshakes on both sides.

---
 rtl/seq_restoring_divider.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative radix-2 restoring divider, one quotient bit per clock
// Optional macro SEQ_DIV_ZERO_FLAG_EN: div_by_zero output and single-cycle divide-by-zero bypass.
module seq_restoring_divider #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
   ,
   output logic          div_by_zero
`endif
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] shift_reg;
   logic [VW-1:0] div_reg;
   logic [VW:0]   prem;
   logic [CW-1:0] cnt;

   logic [VW:0]   shifted;
   logic [VW+1:0] diff;
   logic          q_bit;
   logic [VW:0]   prem_nx;
   logic [DW-1:0] shift_nx;
   logic          zero_div;

   // Extra sign bit on the trial subtraction tells restore from keep.
   always_comb begin
      shifted  = {prem[VW-1:0], shift_reg[DW-1]};
      diff     = {1'b0, shifted} - {2'b00, div_reg};
      q_bit    = ~diff[VW+1];
      prem_nx  = q_bit ? diff[VW:0] : shifted;
      shift_nx = {shift_reg[DW-2:0], q_bit};
   end

`ifdef SEQ_DIV_ZERO_FLAG_EN
   assign zero_div = (divisor == '0);
`else
   assign zero_div = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = zero_div ? DONE : RUN;
         end
         RUN: begin
            if (cnt == '0) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg <= '0;
         div_reg   <= '0;
         prem      <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= dividend;
                  div_reg   <= divisor;
                  prem      <= '0;
                  cnt       <= CW'(DW - 1);
`ifdef SEQ_DIV_ZERO_FLAG_EN
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[VW-1:0];
                     div_by_zero <= 1'b1;
                  end
`endif
               end
            end
            RUN: begin
               shift_reg <= shift_nx;
               prem      <= prem_nx;
               if (cnt == '0) begin
                  // With a zero divisor every trial succeeds, so prem_nx already
                  // carries the low dividend bits; only the quotient is forced.
                  quotient  <= (div_reg == '0) ? '1 : shift_nx;
                  remainder <= prem_nx[VW-1:0];
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
`ifdef SEQ_DIV_ZERO_FLAG_EN
               if (out_ready) div_by_zero <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
